// File: rtl/countdown_timer_if.sv
// Control/status bundle for countdown_timer: the master drives load/start/pause,
// the timer (slave) returns count and status flags.
interface countdown_timer_if #(
  parameter int WIDTH = 16
);
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             start;
  logic             pause;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic             zero;

  modport master (
    output load, load_value, start, pause,
    input  count, busy, done, zero
  );

  modport slave (
    input  load, load_value, start, pause,
    output count, busy, done, zero
  );
endinterface

// File: rtl/countdown_timer.sv
// Prescaled down-counter with IDLE/RUN/HOLD control and a one-cycle done pulse.
// Optional auto-reload at expiry is enabled by defining COUNTDOWN_AUTORELOAD_EN.
module countdown_timer #(
  parameter int WIDTH    = 16,
  parameter int PRESCALE = 1
) (
  input  logic              clk,
  input  logic              reset,
  countdown_timer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_e;

  localparam logic [15:0] PRESC_MAX = 16'(PRESCALE - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [15:0]      presc_q, presc_d;
  logic             done_q,  done_d;
  logic             tick, expire, advance;

`ifdef COUNTDOWN_AUTORELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;
`endif

  // NOTE: every output of this block gets a default before any branch, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    presc_d = presc_q;
    done_d  = 1'b0;
`ifdef COUNTDOWN_AUTORELOAD_EN
    reload_d = reload_q;
`endif
    tick    = (presc_q == PRESC_MAX);
    expire  = tick && (count_q <= WIDTH'(1));
    advance = 1'b0;

    if (bus.load) begin
      count_d = bus.load_value;
      presc_d = '0;
      state_d = IDLE;
`ifdef COUNTDOWN_AUTORELOAD_EN
      reload_d = bus.load_value;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (count_q != '0) begin
              state_d = RUN;
              presc_d = '0;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        // A terminal decrement overrides pause so expiry is never postponed.
        RUN: begin
          if (bus.pause && !expire) state_d = HOLD;
          else                      advance = 1'b1;
        end
        // Leaving HOLD counts as an active cycle, so the delay equals the pause length.
        HOLD: begin
          if (!bus.pause) begin
            state_d = RUN;
            advance = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase

      if (advance) begin
        if (!tick) begin
          presc_d = presc_q + 16'd1;
        end else begin
          presc_d = '0;
          if (expire) begin
            done_d = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
            count_d = reload_q;
            state_d = (reload_q != '0) ? RUN : IDLE;
`else
            count_d = '0;
            state_d = IDLE;
`endif
          end else begin
            count_d = count_q - WIDTH'(1);
          end
        end
      end
    end
  end

  // NOTE: state flops use non-blocking assignments so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      presc_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      presc_q <= presc_d;
      done_q  <= done_d;
    end
  end

`ifdef COUNTDOWN_AUTORELOAD_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) reload_q <= '0;
    else       reload_q <= reload_d;
  end
`endif

  assign bus.count = count_q;
  assign bus.busy  = (state_q != IDLE);
  assign bus.done  = done_q;
  assign bus.zero  = (count_q == '0);

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: one instance at PRESCALE=1, one at PRESCALE=4,
// with hand-computed expected counts and flags.
module tb_countdown_timer;

  logic clk;
  logic reset;
  int   n_vec = 0;
  int   n_bad = 0;

  countdown_timer_if #(.WIDTH(16)) if1 ();
  countdown_timer_if #(.WIDTH(16)) if4 ();

  countdown_timer #(.WIDTH(16), .PRESCALE(1)) u_p1 (.clk(clk), .reset(reset), .bus(if1));
  countdown_timer #(.WIDTH(16), .PRESCALE(4)) u_p4 (.clk(clk), .reset(reset), .bus(if4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
      else begin
        n_bad++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    if1.load = 1'b0; if1.load_value = '0; if1.start = 1'b0; if1.pause = 1'b0;
    if4.load = 1'b0; if4.load_value = '0; if4.start = 1'b0; if4.pause = 1'b0;

    // Reset state, before any clock edge
    #2;
    check("rst_count", if1.count, 0);
    check("rst_busy",  if1.busy,  0);
    check("rst_done",  if1.done,  0);
    check("rst_zero",  if1.zero,  1);
    tick();
    reset = 1'b0;
    tick();

    // PRESCALE=1, load 5: 5,4,3,2,1,0 with a stray start that must be ignored
    if1.load_value = 16'd5; if1.load = 1'b1;
    tick();
    check("p1_loaded", if1.count, 5);
    check("p1_loaded_busy", if1.busy, 0);
    if1.load = 1'b0; if1.start = 1'b1;
    tick();
    if1.start = 1'b0;
    check("p1_run_count", if1.count, 5);
    check("p1_run_busy",  if1.busy,  1);
    for (int i = 4; i >= 1; i--) begin
      tick();
      check($sformatf("p1_count_%0d", i), if1.count, i);
      check($sformatf("p1_nodone_%0d", i), if1.done, 0);
      if1.start = (i == 3);
    end
    tick();
    check("p1_exp_count", if1.count, 0);
    check("p1_exp_done",  if1.done,  1);
    check("p1_exp_busy",  if1.busy,  0);
    check("p1_exp_zero",  if1.zero,  1);
    tick();
    check("p1_done_once", if1.done, 0);
    check("p1_idle_busy", if1.busy, 0);

    // PRESCALE=4, load 3: first decrement 4 cycles after RUN entry, done at 12
    if4.load_value = 16'd3; if4.load = 1'b1;
    tick();
    if4.load = 1'b0; if4.start = 1'b1;
    tick();
    if4.start = 1'b0;
    check("p4_e0_count", if4.count, 3);
    check("p4_e0_busy",  if4.busy,  1);
    repeat (3) tick();
    check("p4_e3_count", if4.count, 3);
    tick();
    check("p4_e4_count", if4.count, 2);
    repeat (7) tick();
    check("p4_e11_count", if4.count, 1);
    check("p4_e11_done",  if4.done,  0);
    tick();
    check("p4_e12_count", if4.count, 0);
    check("p4_e12_done",  if4.done,  1);
    check("p4_e12_busy",  if4.busy,  0);

    // Start with count 0: immediate done pulse, never busy
    if1.load_value = 16'd0; if1.load = 1'b1;
    tick();
    if1.load = 1'b0; if1.start = 1'b1;
    tick();
    if1.start = 1'b0;
    check("z_done", if1.done, 1);
    check("z_busy", if1.busy, 0);
    tick();
    check("z_done_clr", if1.done, 0);
    check("z_busy_idle", if1.busy, 0);

    // Load 10, pause for 7 cycles at count 6: done 7 cycles late (E17 instead of E10)
    if1.load_value = 16'd10; if1.load = 1'b1;
    tick();
    if1.load = 1'b0; if1.start = 1'b1;
    tick();
    if1.start = 1'b0;
    check("pz_e0", if1.count, 10);
    repeat (4) tick();
    check("pz_e4", if1.count, 6);
    if1.pause = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      check($sformatf("pz_hold_count_%0d", k), if1.count, 6);
      check($sformatf("pz_hold_busy_%0d", k),  if1.busy,  1);
    end
    if1.pause = 1'b0;
    tick();
    check("pz_resume", if1.count, 5);
    repeat (4) tick();
    check("pz_e16_count", if1.count, 1);
    check("pz_e16_done",  if1.done,  0);
    tick();
    check("pz_e17_count", if1.count, 0);
    check("pz_e17_done",  if1.done,  1);
    check("pz_e17_busy",  if1.busy,  0);

    // Pause coincident with the terminal decrement: expiry still completes
    if1.load_value = 16'd2; if1.load = 1'b1;
    tick();
    if1.load = 1'b0; if1.start = 1'b1;
    tick();
    if1.start = 1'b0;
    tick();
    check("pt_count1", if1.count, 1);
    if1.pause = 1'b1;
    tick();
    check("pt_count", if1.count, 0);
    check("pt_done",  if1.done,  1);
    check("pt_busy",  if1.busy,  0);
    if1.pause = 1'b0;

    // Asynchronous reset mid-countdown from 0xFFFF
    if1.load_value = 16'hFFFF; if1.load = 1'b1;
    tick();
    if1.load = 1'b0; if1.start = 1'b1;
    tick();
    if1.start = 1'b0;
    repeat (3) tick();
    check("ar_pre_count", if1.count, 16'hFFFC);
    #3 reset = 1'b1;
    #1;
    check("ar_count", if1.count, 0);
    check("ar_busy",  if1.busy,  0);
    check("ar_zero",  if1.zero,  1);
    check("ar_done",  if1.done,  0);
    #2 reset = 1'b0;
    tick();
    check("ar_post_done", if1.done, 0);
    check("ar_post_busy", if1.busy, 0);
    tick();
    check("ar_wait_count", if1.count, 0);
    check("ar_wait_busy",  if1.busy,  0);

    // Load while running aborts silently and parks in IDLE
    if1.load_value = 16'h1234; if1.load = 1'b1;
    tick();
    if1.load = 1'b0; if1.start = 1'b1;
    tick();
    if1.start = 1'b0;
    repeat (2) tick();
    check("ld_run_count", if1.count, 16'h1232);
    if1.load_value = 16'd8; if1.load = 1'b1;
    tick();
    if1.load = 1'b0;
    check("ld_count", if1.count, 8);
    check("ld_busy",  if1.busy,  0);
    check("ld_done",  if1.done,  0);
    tick();
    check("ld_hold_count", if1.count, 8);
    check("ld_hold_busy",  if1.busy,  0);
    check("ld_hold_done",  if1.done,  0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
